msk_modulation_module: RTL

MSK_MODULATION_MODULE -- requirements
Module: msk_modulation_module

---
 rtl/msk_modulation_module.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/msk_modulation_module.sv
// MSK modulator: phase-continuous +/-1 step per sample, quarter-wave I/Q lookup.
// Define MSK_PRECODE_EN to enable XNOR differential precoding of symbol bits.
`timescale 1ns/1ps
module msk_modulation_module #(
    parameter int SAMPLES_PER_SYM = 40,
    parameter int AMPLITUDE       = 29000
) (
    input  logic        logic_clk_in,
    input  logic        logic_rst_in,
    input  logic        tx_enable_in,
    input  logic        bit_in,
    input  logic        bit_valid_in,
    output logic        bit_ready_out,
    output logic [31:0] data_msk_out,
    output logic        data_valid_out,
    output logic        symbol_strobe_out,
    output logic        underflow_out
);

    localparam int CW = $clog2(SAMPLES_PER_SYM + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYM - 1);
`ifdef MSK_PRECODE_EN
    localparam bit PRECODE = 1'b1;
`else
    localparam bit PRECODE = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_p, w_p_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic        r_sym, w_sym_nx;
    logic        r_fill, w_fill_nx;
    logic        r_d, w_d_nx;
    logic        w_ready, w_uf, w_wrap, w_bit;

    logic        r_s1_v, r_s1_st;
    logic [7:0]  r_s1_p;
    logic [31:0] r_data;
    logic        r_valid, r_strobe;

    logic [15:0] w_qrom [0:40];
    logic [7:0]  w_pc;
    logic [6:0]  w_ms, w_mc;
    logic [15:0] w_i, w_q;

    function automatic logic [15:0] f_quarter(input int k);
        real v;
        v = real'(AMPLITUDE) * $sin(6.283185307179586 * real'(k) / 160.0);
        return 16'($rtoi(v + 0.5));
    endfunction

    // {negate, quarter-table index} for sin of phase pp
    function automatic logic [6:0] f_map(input logic [7:0] pp);
        if (pp < 8'd40)       return {1'b0, pp[5:0]};
        else if (pp < 8'd80)  return {1'b0, 6'(8'd80 - pp)};
        else if (pp < 8'd120) return {1'b1, 6'(pp - 8'd80)};
        else                  return {1'b1, 6'(8'd160 - pp)};
    endfunction

    function automatic logic f_code(input logic b, input logic d);
        return PRECODE ? ~(b ^ d) : b;
    endfunction

    for (genvar g = 0; g <= 40; g++) begin : g_rom
        localparam logic [15:0] C = f_quarter(g);
        assign w_qrom[g] = C;
    end

    always_comb begin
        w_state_nx = r_state;
        w_p_nx     = r_p;
        w_cnt_nx   = r_cnt;
        w_sym_nx   = r_sym;
        w_fill_nx  = r_fill;
        w_d_nx     = r_d;
        w_ready    = 1'b0;
        w_uf       = 1'b0;
        w_bit      = 1'b0;
        w_wrap     = (r_cnt == LAST);
        unique case (r_state)
            S_IDLE: begin
                w_ready   = tx_enable_in;
                w_p_nx    = '0;
                w_cnt_nx  = '0;
                w_fill_nx = 1'b1;
                if (tx_enable_in && bit_valid_in) begin
                    w_state_nx = S_ACTIVE;
                    w_bit      = f_code(bit_in, r_d);
                    w_sym_nx   = w_bit;
                    w_d_nx     = w_bit;
                end
            end
            S_ACTIVE: begin
                if (r_sym) w_p_nx = (r_p == 8'd159) ? 8'd0 : r_p + 8'd1;
                else       w_p_nx = (r_p == 8'd0) ? 8'd159 : r_p - 8'd1;
                w_cnt_nx = w_wrap ? '0 : r_cnt + 1'b1;
                w_ready  = w_wrap && tx_enable_in;
                if (w_wrap) begin
                    if (!tx_enable_in) begin
                        w_state_nx = S_IDLE;
                        w_p_nx     = '0;
                    end else begin
                        if (bit_valid_in) begin
                            w_bit = f_code(bit_in, r_d);
                        end else begin
                            w_uf      = 1'b1;
                            w_fill_nx = ~r_fill;
                            w_bit     = f_code(r_fill, r_d);
                        end
                        w_sym_nx = w_bit;
                        w_d_nx   = w_bit;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_cnt   <= '0;
            r_sym   <= 1'b0;
            r_fill  <= 1'b1;
            r_d     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_p     <= w_p_nx;
            r_cnt   <= w_cnt_nx;
            r_sym   <= w_sym_nx;
            r_fill  <= w_fill_nx;
            r_d     <= w_d_nx;
        end
    end

    // cos(p) = sin(p + 40)
    assign w_pc = (r_s1_p >= 8'd120) ? r_s1_p - 8'd120 : r_s1_p + 8'd40;
    assign w_ms = f_map(r_s1_p);
    assign w_mc = f_map(w_pc);
    assign w_q  = w_ms[6] ? -w_qrom[w_ms[5:0]] : w_qrom[w_ms[5:0]];
    assign w_i  = w_mc[6] ? -w_qrom[w_mc[5:0]] : w_qrom[w_mc[5:0]];

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            r_s1_v   <= 1'b0;
            r_s1_st  <= 1'b0;
            r_s1_p   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_s1_v   <= (r_state == S_ACTIVE);
            r_s1_st  <= (r_state == S_ACTIVE) && (r_cnt == '0);
            r_s1_p   <= r_p;
            r_data   <= r_s1_v ? {w_q, w_i} : 32'd0;
            r_valid  <= r_s1_v;
            r_strobe <= r_s1_st;
        end
    end

    assign bit_ready_out     = w_ready && !logic_rst_in;
    assign underflow_out     = w_uf && !logic_rst_in;
    assign data_msk_out      = r_data;
    assign data_valid_out    = r_valid;
    assign symbol_strobe_out = r_strobe;

endmodule
